softusb_tx: RTL and testbench

- Full/low-speed USB line transmitter for the softusb SIE; the transmit-direction counterpart of the SIE receive path.
- Accepts bytes over a valid/ready handshake from the SIE I/O register logic.
- Generates SYNC, NRZI-encodes data with bit stuffing, appends EOP, and drives txp/txm/txoe toward the port transceiver.
- Also emits bare EOPs, used for low-speed keepalive.

---
 rtl/softusb_tx_if.sv | 25 ++
 rtl/softusb_tx.sv | 173 +++++++++++++++++
 tb/tb_softusb_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/softusb_tx_if.sv
// Byte-stream handshake between the softusb SIE register logic and the USB line transmitter.
// The SIE side is the master; the transmitter is the slave.
interface softusb_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       generate_eop;
  logic       tx_busy;

  modport master (
    output tx_data,
    output tx_valid,
    output generate_eop,
    input  tx_ready,
    input  tx_busy
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    input  generate_eop,
    output tx_ready,
    output tx_busy
  );
endinterface

// File: rtl/softusb_tx.sv
// Full/low-speed USB line transmitter: SYNC, NRZI with bit stuffing, EOP, bare keepalive EOP.
// Bit timing assumes a 48 MHz usb_clk (4 clocks per FS bit, 32 per LS bit).
module softusb_tx (
  input  logic        usb_clk,
  input  logic        usb_rst,
  input  logic        low_speed,
  softusb_tx_if.slave bus,
  output logic        txp,
  output logic        txm,
  output logic        txoe
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_EOP  = 2'd3;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  // Line levels for an encoder sitting at J (at_j=1) or K; low speed swaps the pair.
  function automatic logic [1:0] line_of(input logic at_j, input logic slow);
    return (at_j ^ slow) ? 2'b10 : 2'b01;
  endfunction

  logic [1:0] state,    state_nxt;
  logic [4:0] div,      div_nxt;
  logic       ls,       ls_nxt;
  logic [7:0] shreg,    shreg_nxt;
  logic [2:0] bit_cnt,  bit_cnt_nxt;
  logic [2:0] ones_cnt, ones_nxt;
  logic       level_j,  level_j_nxt;
  logic       txp_nxt,  txm_nxt, txoe_nxt;
  logic       ready_q,  ready_nxt;

  logic       strobe;
  logic       send_bit;
  logic       bit_val;
  logic       send_se0;

  assign strobe       = ls ? (div == 5'd31) : (div[1:0] == 2'd3);
  assign bus.tx_ready = ready_q;
  assign bus.tx_busy  = (state != ST_IDLE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_nxt   = state;
    div_nxt     = div + 5'd1;
    ls_nxt      = ls;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    ones_nxt    = ones_cnt;
    level_j_nxt = level_j;
    txp_nxt     = txp;
    txm_nxt     = txm;
    txoe_nxt    = txoe;
    ready_nxt   = 1'b0;
    send_bit    = 1'b0;
    bit_val     = 1'b0;
    send_se0    = 1'b0;

    case (state)
      ST_IDLE: begin
        div_nxt              = '0;
        ls_nxt               = low_speed;
        level_j_nxt          = 1'b1;
        {txp_nxt, txm_nxt}   = line_of(1'b1, low_speed);
        txoe_nxt             = 1'b0;
        if (bus.tx_valid) begin
          state_nxt   = ST_SYNC;
          bit_cnt_nxt = '0;
          shreg_nxt   = SYNC_PATTERN >> 1;
          send_bit    = 1'b1;
          bit_val     = SYNC_PATTERN[0];
        end else if (bus.generate_eop) begin
          state_nxt   = ST_EOP;
          bit_cnt_nxt = '0;
          send_se0    = 1'b1;
        end
      end

      ST_SYNC, ST_DATA: begin
        if (strobe) begin
          // A pending stuff takes the next slot even after the last bit of a byte.
          if (ones_cnt == 3'd6) begin
            send_bit = 1'b1;
            bit_val  = 1'b0;
          end else if (bit_cnt != 3'd7) begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = shreg >> 1;
            send_bit    = 1'b1;
            bit_val     = shreg[0];
          end else if (bus.tx_valid) begin
            state_nxt   = ST_DATA;
            bit_cnt_nxt = '0;
            shreg_nxt   = {1'b0, bus.tx_data[7:1]};
            ready_nxt   = 1'b1;
            send_bit    = 1'b1;
            bit_val     = bus.tx_data[0];
          end else begin
            state_nxt   = ST_EOP;
            bit_cnt_nxt = '0;
            send_se0    = 1'b1;
          end
        end
      end

      ST_EOP: begin
        if (strobe) begin
          if (bit_cnt == 3'd0) begin
            bit_cnt_nxt = 3'd1;
            send_se0    = 1'b1;
          end else if (bit_cnt == 3'd1) begin
            bit_cnt_nxt        = 3'd2;
            level_j_nxt        = 1'b1;
            {txp_nxt, txm_nxt} = line_of(1'b1, ls);
          end else begin
            state_nxt          = ST_IDLE;
            bit_cnt_nxt        = '0;
            level_j_nxt        = 1'b1;
            {txp_nxt, txm_nxt} = line_of(1'b1, ls);
            txoe_nxt           = 1'b0;
          end
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it; runs of 1s feed the stuffing counter.
    if (send_bit) begin
      level_j_nxt        = bit_val ? level_j : ~level_j;
      ones_nxt           = bit_val ? ones_cnt + 3'd1 : 3'd0;
      {txp_nxt, txm_nxt} = line_of(level_j_nxt, ls_nxt);
      txoe_nxt           = 1'b1;
    end

    if (send_se0) begin
      {txp_nxt, txm_nxt} = 2'b00;
      txoe_nxt           = 1'b1;
      ones_nxt           = 3'd0;
    end
  end

  always_ff @(posedge usb_clk) begin
    if (usb_rst) begin
      state    <= ST_IDLE;
      div      <= '0;
      ls       <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      ones_cnt <= '0;
      level_j  <= 1'b1;
      txp      <= 1'b1;
      txm      <= 1'b0;
      txoe     <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      // NOTE: registers take their next values with non-blocking assignments only.
      state    <= state_nxt;
      div      <= div_nxt;
      ls       <= ls_nxt;
      shreg    <= shreg_nxt;
      bit_cnt  <= bit_cnt_nxt;
      ones_cnt <= ones_nxt;
      level_j  <= level_j_nxt;
      txp      <= txp_nxt;
      txm      <= txm_nxt;
      txoe     <= txoe_nxt;
      ready_q  <= ready_nxt;
    end
  end

endmodule

// File: tb/tb_softusb_tx.sv
// Scoreboard bench for softusb_tx: a stream-level model predicts every packet's line waveform
// and tx_ready positions; a monitor captures each txoe burst and compares against the queue.
module tb_softusb_tx;

  logic usb_clk   = 1'b0;
  logic usb_rst   = 1'b1;
  logic low_speed = 1'b0;
  logic txp, txm, txoe;

  softusb_tx_if bus ();

  softusb_tx dut (
    .usb_clk   (usb_clk),
    .usb_rst   (usb_rst),
    .low_speed (low_speed),
    .bus       (bus),
    .txp       (txp),
    .txm       (txm),
    .txoe      (txoe)
  );

  always #5 usb_clk = ~usb_clk;

  int checks = 0;
  int errors = 0;

  // Expected packets, oldest first; per-bit line levels and ready slots are flattened.
  int         exp_nbits[$];
  int         exp_period[$];
  int         exp_nready[$];
  int         exp_ready_pos[$];
  logic [1:0] exp_lines[$];

  logic [7:0] pkt_bytes[$];
  logic [1:0] cap[$];
  int         rq[$];
  int         stray     = 0;
  int         skip_req  = 0;
  int         skip_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: SYNC + bytes as a bit stream, insert a 0 after every six 1s, NRZI from J, then EOP.
  function automatic void build_expected(input bit ls, input bit bare);
    logic [1:0] jl, kl, cur;
    bit         raw[$];
    bit         out[$];
    int         starts[$];
    int         ready_pos[$];
    int         run;
    jl = ls ? 2'b01 : 2'b10;
    kl = ls ? 2'b10 : 2'b01;
    if (!bare) begin
      for (int i = 0; i < 8; i++) raw.push_back(i == 7);
      foreach (pkt_bytes[b]) begin
        starts.push_back(raw.size());
        for (int i = 0; i < 8; i++) raw.push_back(pkt_bytes[b][i]);
      end
    end
    run = 0;
    for (int i = 0; i < raw.size(); i++) begin
      if (starts.size() > 0 && starts[0] == i) begin
        ready_pos.push_back(out.size());
        void'(starts.pop_front());
      end
      out.push_back(raw[i]);
      run = raw[i] ? run + 1 : 0;
      if (run == 6) begin
        out.push_back(1'b0);
        run = 0;
      end
    end
    cur = jl;
    foreach (out[i]) begin
      if (!out[i]) cur = (cur == jl) ? kl : jl;
      exp_lines.push_back(cur);
    end
    exp_lines.push_back(2'b00);
    exp_lines.push_back(2'b00);
    exp_lines.push_back(jl);
    exp_nbits.push_back(out.size() + 3);
    exp_period.push_back(ls ? 32 : 4);
    exp_nready.push_back(ready_pos.size());
    foreach (ready_pos[i]) exp_ready_pos.push_back(ready_pos[i]);
  endfunction

  task automatic finish_packet();
    int         nb, p, nr, e;
    logic [2:0] a;
    logic [1:0] el;
    if (skip_done < skip_req) begin
      skip_done++;
      return;
    end
    if (exp_nbits.size() == 0) begin
      check("unexpected_packet_cycles", cap.size(), 0);
      return;
    end
    nb = exp_nbits.pop_front();
    p  = exp_period.pop_front();
    check("txoe_cycles", cap.size(), nb * p);
    for (int k = 0; k < nb; k++) begin
      el = exp_lines.pop_front();
      a  = 3'b100;
      if (k * p < cap.size()) begin
        a = {1'b0, cap[k*p]};
        for (int i = 0; i < p; i++)
          if (k * p + i < cap.size() && cap[k*p+i] !== el) a = {1'b0, cap[k*p+i]};
      end
      check($sformatf("bit%0d_line", k), a, {1'b0, el});
    end
    nr = exp_nready.pop_front();
    check("ready_count", rq.size(), nr);
    for (int r = 0; r < nr; r++) begin
      e = exp_ready_pos.pop_front();
      check($sformatf("ready%0d_cycle", r), (r < rq.size()) ? rq[r] : -1, e * p);
    end
  endtask

  // Monitor: samples on the falling edge, one capture per txoe burst.
  initial begin
    bit capturing = 1'b0;
    forever begin
      @(negedge usb_clk);
      if (txoe) begin
        if (!capturing) begin
          capturing = 1'b1;
          cap.delete();
          rq.delete();
        end
        cap.push_back({txp, txm});
        if (bus.tx_ready) rq.push_back(cap.size() - 1);
      end else begin
        if (bus.tx_ready) stray++;
        if (capturing) begin
          capturing = 1'b0;
          finish_packet();
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.tx_busy && n < 5000) begin
      @(negedge usb_clk);
      n++;
    end
    if (bus.tx_busy) check("idle_timeout", bus.tx_busy, 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge usb_clk);
      n++;
    end while (!bus.tx_ready && n < 3000);
    if (!bus.tx_ready) check("ready_timeout", bus.tx_ready, 1);
  endtask

  task automatic run_packet(input bit ls, input bit bare, input bit both);
    wait_idle();
    @(negedge usb_clk);
    low_speed = ls;
    build_expected(ls, bare);
    if (bare) begin
      bus.generate_eop = 1'b1;
      @(negedge usb_clk);
      bus.generate_eop = 1'b0;
    end else begin
      bus.tx_data      = pkt_bytes[0];
      bus.tx_valid     = 1'b1;
      bus.generate_eop = both;
      @(negedge usb_clk);
      bus.generate_eop = 1'b0;
      for (int b = 0; b < pkt_bytes.size(); b++) begin
        wait_ready();
        if (b + 1 < pkt_bytes.size()) bus.tx_data = pkt_bytes[b+1];
        // Inputs wiggle mid-byte; only the values present at the next load point matter.
        for (int i = 0; i < 16; i++) begin
          @(negedge usb_clk);
          bus.tx_valid     = 1'($urandom);
          bus.generate_eop = 1'($urandom);
          low_speed        = 1'($urandom);
        end
        bus.tx_valid     = (b + 1 < pkt_bytes.size());
        bus.generate_eop = 1'b0;
        low_speed        = ls;
      end
    end
    wait_idle();
    repeat (2) @(negedge usb_clk);
    check(ls ? "idle_j_ls" : "idle_j_fs", {txp, txm, txoe}, ls ? 3'b010 : 3'b100);
  endtask

  initial begin
    int n;
    bit ls, bare;
    #900_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ls;
    int n;
    bus.tx_data      = 8'h00;
    bus.tx_valid     = 1'b0;
    bus.generate_eop = 1'b0;

    repeat (3) @(negedge usb_clk);
    check("rst_txoe", txoe, 0);
    check("rst_txp", txp, 1);
    check("rst_txm", txm, 0);
    check("rst_ready", bus.tx_ready, 0);
    check("rst_busy", bus.tx_busy, 0);
    usb_rst = 1'b0;
    repeat (2) @(negedge usb_clk);
    check("idle_j_fs_start", {txp, txm, txoe}, 3'b100);

    pkt_bytes = '{8'hA5};              run_packet(1'b0, 1'b0, 1'b0);
    pkt_bytes = '{8'hFF};              run_packet(1'b0, 1'b0, 1'b0);
    pkt_bytes = '{8'h00};              run_packet(1'b1, 1'b0, 1'b0);
    pkt_bytes = '{8'h01, 8'h7E, 8'h3F}; run_packet(1'b0, 1'b0, 1'b0);
    run_packet(1'b0, 1'b1, 1'b0);
    run_packet(1'b1, 1'b1, 1'b0);
    pkt_bytes = '{8'h5A};              run_packet(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a byte: the line returns to idle at once with no EOP.
    wait_idle();
    @(negedge usb_clk);
    low_speed    = 1'b0;
    skip_req++;
    bus.tx_data  = 8'hFF;
    bus.tx_valid = 1'b1;
    repeat (44) @(negedge usb_clk);
    check("busy_before_rst", bus.tx_busy, 1);
    usb_rst      = 1'b1;
    bus.tx_valid = 1'b0;
    @(negedge usb_clk);
    check("midrst_txoe", txoe, 0);
    check("midrst_txp", txp, 1);
    check("midrst_txm", txm, 0);
    check("midrst_busy", bus.tx_busy, 0);
    usb_rst = 1'b0;
    pkt_bytes = '{8'hFF};
    run_packet(1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      ls = ($urandom_range(0, 3) == 0);
      n  = ls ? $urandom_range(1, 2) : $urandom_range(1, 4);
      pkt_bytes.delete();
      for (int i = 0; i < n; i++)
        pkt_bytes.push_back(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom));
      run_packet(ls, $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    end

    wait_idle();
    repeat (4) @(negedge usb_clk);
    check("pending_expected", exp_nbits.size(), 0);
    check("stray_ready", stray, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
